mux_lut_sweep: RTL and testbench

MUX_LUT_SWEEP -- requirements
Module: mux_lut_sweep

---
 rtl/mux_lut_pkg.sv | 36 +++
 rtl/mux_lut_eval.sv | 22 ++
 rtl/mux_lut_sweep.sv | 122 ++++++++++++
 tb/tb_mux_lut_sweep.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_lut_pkg.sv
// Shared types for the mux-based LUT sweeper.
//   code_e      : two-bit data-line code stored per mux input
//   state_e     : sweep controller state
//   decode_bit  : resolves a data-line code against the MSB variable
package mux_lut_pkg;

  localparam int unsigned CODE_W = 2;

  typedef enum logic [CODE_W-1:0] {
    CODE_ZERO = 2'b00,
    CODE_ONE  = 2'b01,
    CODE_VAR  = 2'b10,
    CODE_NVAR = 2'b11
  } code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SWEEP = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Value presented on one mux data line for a given MSB variable.
  function automatic logic decode_bit(input logic [CODE_W-1:0] code, input logic msb);
    logic res;
    res = 1'b0;
    case (code)
      CODE_ZERO: res = 1'b0;
      CODE_ONE:  res = 1'b1;
      CODE_VAR:  res = msb;
      CODE_NVAR: res = ~msb;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mux_lut_eval.sv
// Combinational evaluation of one minterm against the code table.
//   lut   : 2^SEL_W two-bit codes, entry i drives mux data line i
//   idx   : minterm; low SEL_W bits select the line, top bit is the MSB variable
//   bit_c : function value f(idx)
module mux_lut_eval
  import mux_lut_pkg::*;
#(
  parameter int unsigned SEL_W = 3
) (
  input  logic [(1<<SEL_W)-1:0][CODE_W-1:0] lut,
  input  logic [SEL_W:0]                    idx,
  output logic                              bit_c
);

  logic [CODE_W-1:0] code;

  always_comb begin
    code  = lut[idx[SEL_W-1:0]];
    bit_c = decode_bit(code, idx[SEL_W]);
  end

endmodule

// File: rtl/mux_lut_sweep.sv
// Programmable 2^SEL_W:1 mux implementing an NVAR-input boolean function,
// with a live registered output and a one-shot sweep over all minterms.
//   clk, rst               : clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_code : write one data-line code (ignored while busy)
//   var_in                 : live variables, MSB is the data-line variable
//   start                  : sweep request (ignored while busy)
//   y                      : registered f(var_in)
//   sw_valid/sw_idx/sw_y   : sweep samples, minterms 0..M-1 in order
//   busy                   : sweep in progress, through the done cycle
//   done                   : one-cycle pulse after the last sample
module mux_lut_sweep
  import mux_lut_pkg::*;
#(
  parameter  int unsigned SEL_W = 3,
  localparam int unsigned NVAR  = SEL_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [SEL_W-1:0]  cfg_addr,
  input  logic [CODE_W-1:0] cfg_code,
  input  logic [NVAR-1:0]   var_in,
  input  logic              start,
  output logic              y,
  output logic              sw_valid,
  output logic [NVAR-1:0]   sw_idx,
  output logic              sw_y,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NLINE = 1 << SEL_W;
  localparam int unsigned M     = 1 << NVAR;

  logic [NLINE-1:0][CODE_W-1:0] lut;
  logic [NLINE-1:0][CODE_W-1:0] lut_nxt_c;
  state_e                       state;
  logic [NVAR-1:0]              cnt;
  logic                         live_c;
  logic                         sweep_c;

  // Table with this cycle's write applied; the sweep path reads it so a
  // write landing on the start cycle is already visible to minterm 0.
  always_comb begin
    lut_nxt_c = lut;
    if (cfg_we && (state == ST_IDLE)) begin
      lut_nxt_c[cfg_addr] = cfg_code;
    end
  end

  mux_lut_eval #(.SEL_W(SEL_W)) u_eval_live (
    .lut   (lut),
    .idx   (var_in),
    .bit_c (live_c)
  );

  mux_lut_eval #(.SEL_W(SEL_W)) u_eval_sweep (
    .lut   (lut_nxt_c),
    .idx   (cnt),
    .bit_c (sweep_c)
  );

  // State tracks what the outputs show: SWEEP while samples are valid,
  // DONE during the done pulse, IDLE when not busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      lut      <= '0;
      state    <= ST_IDLE;
      cnt      <= '0;
      y        <= 1'b0;
      sw_valid <= 1'b0;
      sw_idx   <= '0;
      sw_y     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      lut  <= lut_nxt_c;
      y    <= live_c;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          sw_valid <= 1'b0;
          busy     <= 1'b0;
          if (start) begin
            // cnt is 0 in IDLE, so minterm 0 is emitted on the accept edge
            sw_valid <= 1'b1;
            sw_idx   <= cnt;
            sw_y     <= sweep_c;
            cnt      <= cnt + NVAR'(1);
            busy     <= 1'b1;
            state    <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (sw_idx == NVAR'(M - 1)) begin
            sw_valid <= 1'b0;
            done     <= 1'b1;
            cnt      <= '0;
            state    <= ST_DONE;
          end else begin
            sw_valid <= 1'b1;
            sw_idx   <= cnt;
            sw_y     <= sweep_c;
            cnt      <= cnt + NVAR'(1);
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          sw_valid <= 1'b0;
          busy     <= 1'b0;
          cnt      <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_lut_sweep.sv
// Directed bench for mux_lut_sweep: SEL_W=3 instance (live path, sweep,
// busy-time requests, reset mid-sweep) and SEL_W=2 instance (sweep).
module tb_mux_lut_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SEL_W=3 instance
  logic       a_rst, a_cfg_we, a_start;
  logic [2:0] a_cfg_addr;
  logic [1:0] a_cfg_code;
  logic [3:0] a_var_in;
  logic       a_y, a_sw_valid, a_sw_y, a_busy, a_done;
  logic [3:0] a_sw_idx;

  // SEL_W=2 instance
  logic       b_rst, b_cfg_we, b_start;
  logic [1:0] b_cfg_addr;
  logic [1:0] b_cfg_code;
  logic [2:0] b_var_in;
  logic       b_y, b_sw_valid, b_sw_y, b_busy, b_done;
  logic [2:0] b_sw_idx;

  mux_lut_sweep #(.SEL_W(3)) u_dut_a (
    .clk(clk), .rst(a_rst), .cfg_we(a_cfg_we), .cfg_addr(a_cfg_addr),
    .cfg_code(a_cfg_code), .var_in(a_var_in), .start(a_start), .y(a_y),
    .sw_valid(a_sw_valid), .sw_idx(a_sw_idx), .sw_y(a_sw_y),
    .busy(a_busy), .done(a_done)
  );

  mux_lut_sweep #(.SEL_W(2)) u_dut_b (
    .clk(clk), .rst(b_rst), .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr),
    .cfg_code(b_cfg_code), .var_in(b_var_in), .start(b_start), .y(b_y),
    .sw_valid(b_sw_valid), .sw_idx(b_sw_idx), .sw_y(b_sw_y),
    .busy(b_busy), .done(b_done)
  );

  int n_err = 0;
  int n_chk = 0;

  // Hand-derived truth tables, bit m = f(m).
  // A: sigma(1,3,6,8,10,11,14)  B: sigma(0,2,4,5)
  logic [15:0] a_exp = 16'h4D4A;
  logic [7:0]  b_exp = 8'h35;
  logic [1:0]  a_codes [8] = '{2'b10, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
  logic [1:0]  b_codes [4] = '{2'b01, 2'b10, 2'b11, 2'b00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sweep on instance A. mode 0: plain; 1: start+write at idx 4; 2: reset at idx 5.
  task automatic sweep_a(input int mode);
    int   n_valid = 0;
    int   n_busy  = 0;
    int   n_done  = 0;
    logic prev_valid = 1'b0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (a_busy) n_busy++;
      if (a_sw_valid) begin
        if (n_valid < 16) begin
          check("sweep_idx", 32'(a_sw_idx), 32'(n_valid));
          check("sweep_y", 32'(a_sw_y), 32'(a_exp[n_valid]));
        end
        n_valid++;
      end
      if (a_done) begin
        n_done++;
        check("done_follows_last", 32'({prev_valid, a_sw_valid}), 32'(2'b10));
      end
      prev_valid = a_sw_valid;
      a_start  = 1'b0;
      a_cfg_we = 1'b0;
      if (mode == 1 && a_sw_valid && a_sw_idx == 4'd4) begin
        a_start    = 1'b1;
        a_cfg_we   = 1'b1;
        a_cfg_addr = 3'd3;
        a_cfg_code = 2'b00;
      end
      if (mode == 2 && a_sw_valid && a_sw_idx == 4'd5) begin
        a_rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 32'(a_sw_valid), 32'(0));
        check("rst_mid_busy", 32'(a_busy), 32'(0));
        a_rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (a_done) n_done++;
        end
        check("rst_mid_no_done", 32'(n_done), 32'(0));
        return;
      end
      if (n_done > 0 && !a_done) break;
      @(negedge clk);
    end
    check("sweep_count", 32'(n_valid), 32'(16));
    check("busy_cycles", 32'(n_busy), 32'(17));
    check("done_pulses", 32'(n_done), 32'(1));
  endtask

  initial begin
    a_rst = 1'b1; a_cfg_we = 1'b0; a_start = 1'b0;
    a_cfg_addr = '0; a_cfg_code = '0; a_var_in = '0;
    b_rst = 1'b1; b_cfg_we = 1'b0; b_start = 1'b0;
    b_cfg_addr = '0; b_cfg_code = '0; b_var_in = '0;

    // Reset held two cycles while var_in moves
    repeat (2) begin
      @(negedge clk);
      a_var_in = a_var_in + 4'd5;
      b_var_in = b_var_in + 3'd3;
    end
    check("rst_y", 32'(a_y), 32'(0));
    check("rst_valid", 32'(a_sw_valid), 32'(0));
    check("rst_busy", 32'(a_busy), 32'(0));
    check("rst_done", 32'(a_done), 32'(0));
    check("rst_b_busy", 32'(b_busy), 32'(0));
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Cleared table: every minterm evaluates to 0
    for (int v = 0; v < 16; v++) begin
      a_var_in = 4'(v);
      @(negedge clk);
      check("rst_table_y", 32'(a_y), 32'(0));
    end

    // Program table A
    for (int i = 0; i < 8; i++) begin
      a_cfg_we = 1'b1; a_cfg_addr = 3'(i); a_cfg_code = a_codes[i];
      @(negedge clk);
    end
    a_cfg_we = 1'b0;

    // Live evaluation
    a_var_in = 4'b1010; @(negedge clk); check("live_1010", 32'(a_y), 32'(1));
    a_var_in = 4'b0000; @(negedge clk); check("live_0000", 32'(a_y), 32'(0));
    a_var_in = 4'b1110; @(negedge clk); check("live_1110", 32'(a_y), 32'(1));

    sweep_a(0);
    @(negedge clk);

    // Busy-time start and write are dropped
    sweep_a(1);
    @(negedge clk);
    a_var_in = 4'b0011; @(negedge clk); check("write_dropped", 32'(a_y), 32'(1));

    // Reset mid-sweep, then table reads all zero
    sweep_a(2);
    for (int v = 0; v < 16; v++) begin
      a_var_in = 4'(v);
      @(negedge clk);
      check("post_rst_y", 32'(a_y), 32'(0));
    end

    // SEL_W=2 instance
    for (int i = 0; i < 4; i++) begin
      b_cfg_we = 1'b1; b_cfg_addr = 2'(i); b_cfg_code = b_codes[i];
      @(negedge clk);
    end
    b_cfg_we = 1'b0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    begin
      int   nv = 0;
      int   nd = 0;
      logic pv = 1'b0;
      for (int c = 0; c < 30; c++) begin
        if (b_sw_valid) begin
          if (nv < 8) begin
            check("b_sweep_idx", 32'(b_sw_idx), 32'(nv));
            check("b_sweep_y", 32'(b_sw_y), 32'(b_exp[nv]));
          end
          nv++;
        end
        if (b_done) begin
          nd++;
          check("b_done_follows_last", 32'({pv, b_sw_valid}), 32'(2'b10));
          check("b_done_after_idx7", 32'(b_sw_idx), 32'(7));
        end
        pv = b_sw_valid;
        if (nd > 0 && !b_done) break;
        @(negedge clk);
      end
      check("b_sweep_count", 32'(nv), 32'(8));
      check("b_done_pulses", 32'(nd), 32'(1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
